// File: rtl/fib_sched_if.sv
// Bundle of requester-side and engine-side signals around the shared Fibonacci engine.
// The scheduler uses the slave view; clients, the engine and benches use the master view.
interface fib_sched_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]    req;
    logic [16*N_REQ-1:0] req_din;
    logic [N_REQ-1:0]    ack;
    logic [N_REQ-1:0]    rsp_valid;
    logic [15:0]         rsp_data;
    logic                rsp_err;
    logic                busy;
    logic                eng_start;
    logic [15:0]         eng_din;
    logic [15:0]         eng_dout;
    logic                eng_done;

    modport slave (
        input  req, req_din, eng_dout, eng_done,
        output ack, rsp_valid, rsp_data, rsp_err, busy, eng_start, eng_din
    );

    modport master (
        output req, req_din, eng_dout, eng_done,
        input  ack, rsp_valid, rsp_data, rsp_err, busy, eng_start, eng_din
    );
endinterface

// File: rtl/fib_sched.sv
// Round-robin scheduler sharing one Fibonacci engine among N_REQ requesters,
// with a saturating watchdog that turns a hung engine job into an error response.
module fib_sched #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 70000
) (
    input  logic        clk,
    input  logic        reset_n,
    fib_sched_if.slave  bus
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int SW    = ID_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   id;
    logic [ID_W-1:0]   win_id;
    logic [ID_W-1:0]   ptr_nxt;
    logic [SW-1:0]     arb_sum;
    logic [SW-1:0]     id_inc;
    logic [N_REQ-1:0]  rot;
    logic              win_found;
    logic [15:0]       win_din;
    logic [TMR_W-1:0]  timer;
    logic [15:0]       rsp_data_q;
    logic              rsp_err_q;
    logic [15:0]       eng_din_q;

    // Rotate the request vector so bit 0 is the requester at ptr; the lowest
    // set bit of the rotated vector is the round-robin winner.
    always_comb begin
        rot       = N_REQ'({bus.req, bus.req} >> ptr);
        win_found = 1'b0;
        win_id    = ptr;
        win_din   = '0;
        arb_sum   = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            if (rot[off]) begin
                win_found = 1'b1;
                arb_sum   = {1'b0, ptr} + SW'(off);
                if (arb_sum >= SW'(N_REQ)) begin
                    arb_sum = arb_sum - SW'(N_REQ);
                end
                win_id = arb_sum[ID_W-1:0];
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (win_id == ID_W'(i)) begin
                win_din = bus.req_din[16*i +: 16];
            end
        end
    end

    assign id_inc  = {1'b0, id} + SW'(1);
    assign ptr_nxt = (id_inc == SW'(N_REQ)) ? '0 : id_inc[ID_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Done is checked before the watchdog so a completion in the final timer cycle still succeeds.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (win_found) state_nxt = ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT:  if (bus.eng_done || timer == TMR_LAST) state_nxt = RESP;
            RESP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr        <= '0;
            id         <= '0;
            timer      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            eng_din_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        id        <= win_id;
                        eng_din_q <= win_din;
                    end
                end
                ISSUE: timer <= '0;
                WAIT: begin
                    if (timer != TMR_MAX) begin
                        timer <= timer + 1'b1;
                    end
                    if (bus.eng_done) begin
                        rsp_data_q <= bus.eng_dout;
                        rsp_err_q  <= 1'b0;
                    end else if (timer == TMR_LAST) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                    end
                end
                RESP: ptr <= ptr_nxt;
                default: ;
            endcase
        end
    end

    assign bus.ack       = (state == ISSUE) ? (N_REQ'(1) << id) : '0;
    assign bus.rsp_valid = (state == RESP)  ? (N_REQ'(1) << id) : '0;
    assign bus.eng_start = (state == ISSUE);
    assign bus.busy      = (state != IDLE);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.eng_din   = eng_din_q;

endmodule

// File: tb/tb_fib_sched.sv
// Bench for fib_sched: a latency-programmable Fibonacci engine model, a table of
// directed jobs, hand-written reset/stray-done sequences and random jobs checked against a round-robin model.
module tb_fib_sched;

    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 20;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    fib_sched_if #(.N_REQ(N_REQ)) bus();

    fib_sched #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  mask;
        logic [63:0] din;
        int          lat;
        int          exp_id;
        logic [15:0] exp_data;
        logic        exp_err;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int model_ptr = 0;
    int eng_lat = 0;
    int eng_cnt = 0;
    int stray_req = 0;
    int stray_seen = 0;
    logic [15:0] eng_val;

    always @(posedge clk) cyc++;

    function automatic logic [15:0] fib(input logic [15:0] n);
        logic [15:0] a = 16'd0;
        logic [15:0] b = 16'd1;
        logic [15:0] t;
        for (int i = 0; i < int'(n); i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int rrPick(input logic [3:0] mask, input int ptr);
        for (int off = 0; off < N_REQ; off++) begin
            if (mask[(ptr + off) % N_REQ]) return (ptr + off) % N_REQ;
        end
        return -1;
    endfunction

    // Engine model: done arrives eng_lat cycles after the ISSUE cycle; eng_lat of 0 never completes.
    always @(negedge clk) begin
        bus.eng_done = 1'b0;
        if (!reset_n) begin
            eng_cnt      = 0;
            bus.eng_dout = 16'd0;
        end else begin
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    bus.eng_done = 1'b1;
                    bus.eng_dout = eng_val;
                end
            end
            if (bus.eng_start) begin
                eng_cnt = eng_lat;
                eng_val = fib(bus.eng_din);
            end
            if (stray_req != stray_seen) begin
                stray_seen   = stray_req;
                bus.eng_done = 1'b1;
                bus.eng_dout = 16'hBEEF;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] mask, input logic [63:0] din, input int lat,
                                 input int exp_id, input logic [15:0] exp_data, input logic exp_err);
        int n;
        int exp_lat;
        bus.req_din = din;
        bus.req     = mask;
        eng_lat     = lat;
        n = 0;
        do begin
            step();
            n++;
        end while (bus.ack == '0 && n < 10);
        checkOutput("ack_latency", n, 1);
        checkOutput("ack", int'(bus.ack), 1 << exp_id);
        checkOutput("eng_start", int'(bus.eng_start), 1);
        checkOutput("eng_din", int'(bus.eng_din), int'(din[16*exp_id +: 16]));
        checkOutput("busy_issue", int'(bus.busy), 1);
        bus.req = '0;
        n = 0;
        do begin
            step();
            n++;
            checkOutput("eng_start_wait", int'(bus.eng_start), 0);
        end while (bus.rsp_valid == '0 && n < TIMEOUT + 10);
        exp_lat = (lat == 0) ? TIMEOUT + 1 : lat + 1;
        checkOutput("rsp_latency", n, exp_lat);
        checkOutput("rsp_valid", int'(bus.rsp_valid), 1 << exp_id);
        checkOutput("rsp_data", int'(bus.rsp_data), int'(exp_data));
        checkOutput("rsp_err", int'(bus.rsp_err), int'(exp_err));
        step();
        checkOutput("busy_idle", int'(bus.busy), 0);
        checkOutput("rsp_valid_idle", int'(bus.rsp_valid), 0);
        checkOutput("rsp_data_hold", int'(bus.rsp_data), int'(exp_data));
        model_ptr = (exp_id + 1) % N_REQ;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        tbl [10];
        logic [3:0]  rmask;
        logic [63:0] rdin;
        int          rlat;
        int          w;

        tbl[0] = '{4'b1111, {16'd4, 16'd3, 16'd2, 16'd1}, 5, 0, 16'd1, 1'b0};
        tbl[1] = '{4'b1111, {16'd4, 16'd3, 16'd2, 16'd1}, 5, 1, 16'd1, 1'b0};
        tbl[2] = '{4'b1111, {16'd4, 16'd3, 16'd2, 16'd1}, 5, 2, 16'd2, 1'b0};
        tbl[3] = '{4'b1111, {16'd4, 16'd3, 16'd2, 16'd1}, 5, 3, 16'd3, 1'b0};
        tbl[4] = '{4'b1111, {16'd4, 16'd3, 16'd2, 16'd1}, 3, 0, 16'd1, 1'b0};
        tbl[5] = '{4'b1111, {16'd4, 16'd3, 16'd2, 16'd1}, 3, 1, 16'd1, 1'b0};
        tbl[6] = '{4'b0100, {16'd0, 16'd10, 16'd0, 16'd0}, 12, 2, 16'd55, 1'b0};
        tbl[7] = '{4'b0010, {16'd0, 16'd0, 16'd5, 16'd0}, 0, 1, 16'd0, 1'b1};
        tbl[8] = '{4'b1001, {16'd20, 16'd0, 16'd0, 16'd3}, 3, 3, 16'd6765, 1'b0};
        tbl[9] = '{4'b0001, {16'd0, 16'd0, 16'd0, 16'd6}, TIMEOUT, 0, 16'd8, 1'b0};

        bus.req     = '0;
        bus.req_din = '0;
        reset_n     = 1'b0;
        repeat (3) step();
        checkOutput("rst_ack", int'(bus.ack), 0);
        checkOutput("rst_rsp_valid", int'(bus.rsp_valid), 0);
        checkOutput("rst_busy", int'(bus.busy), 0);
        checkOutput("rst_eng_start", int'(bus.eng_start), 0);
        checkOutput("rst_rsp_err", int'(bus.rsp_err), 0);
        checkOutput("rst_rsp_data", int'(bus.rsp_data), 0);
        checkOutput("rst_eng_din", int'(bus.eng_din), 0);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checkOutput("quiet_ack", int'(bus.ack), 0);
            checkOutput("quiet_busy", int'(bus.busy), 0);
        end

        for (int t = 0; t < 10; t++) begin
            applyStimulus(tbl[t].mask, tbl[t].din, tbl[t].lat,
                          tbl[t].exp_id, tbl[t].exp_data, tbl[t].exp_err);
        end

        stray_req++;
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("stray_rsp_valid", int'(bus.rsp_valid), 0);
            checkOutput("stray_busy", int'(bus.busy), 0);
            checkOutput("stray_rsp_data", int'(bus.rsp_data), 8);
        end

        bus.req_din = {16'd0, 16'd0, 16'd9, 16'd0};
        bus.req     = 4'b0010;
        eng_lat     = 0;
        step();
        checkOutput("midrst_ack", int'(bus.ack), 2);
        bus.req = '0;
        repeat (5) step();
        checkOutput("midrst_busy_wait", int'(bus.busy), 1);
        reset_n = 1'b0;
        step();
        checkOutput("midrst_busy", int'(bus.busy), 0);
        checkOutput("midrst_eng_din", int'(bus.eng_din), 0);
        checkOutput("midrst_rsp_data", int'(bus.rsp_data), 0);
        reset_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            checkOutput("abandoned_rsp", int'(bus.rsp_valid), 0);
        end
        model_ptr = 0;
        applyStimulus(4'b1001, {16'd7, 16'd0, 16'd0, 16'd2}, 4, 0, 16'd1, 1'b0);
        applyStimulus(4'b1000, {16'd7, 16'd0, 16'd0, 16'd0}, 9, 3, 16'd13, 1'b0);

        for (int j = 0; j < 40; j++) begin
            rmask = 4'($urandom_range(1, 15));
            for (int i = 0; i < N_REQ; i++) begin
                rdin[16*i +: 16] = 16'($urandom_range(0, 24));
            end
            rlat = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
            w = rrPick(rmask, model_ptr);
            applyStimulus(rmask, rdin, rlat, w,
                          (rlat == 0) ? 16'd0 : fib(rdin[16*w +: 16]), (rlat == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fib_sched.md
# fib_sched

Round-robin scheduler that shares a single Fibonacci engine among `N_REQ` requesters. It accepts one request at a time, issues a start pulse and operand to the engine, and waits for the engine's done pulse or a watchdog timeout. It then returns the 16-bit result with an error flag to the originating requester. It sits between the client ports and the engine instance; the engine itself is unchanged.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 70000: cycles in WAIT before a job is declared hung; must exceed worst-case engine latency (din=65535).
- `clk` in 1: single clock, all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in N_REQ: per-requester request level.
- `req_din` in 16*N_REQ: operand for requester i at bits [16i+15:16i].
- `ack` out N_REQ: one-cycle pulse telling requester i its request was taken.
- `rsp_valid` out N_REQ: one-cycle pulse telling requester i its result is on `rsp_data`/`rsp_err`.
- `rsp_data` out 16: result, shared by all requesters.
- `rsp_err` out 1: 1 means timeout (`rsp_data` = 0).
- `busy` out 1: high in every state except IDLE.
- `eng_start` out 1: engine start, one-cycle pulse.
- `eng_din` out 16: engine operand, held stable from ISSUE until the next ISSUE.
- `eng_dout` in 16: engine result.
- `eng_done` in 1: engine completion pulse; `eng_dout` is valid in the same cycle.

## Operation
- States:
  - IDLE: if any `req` bit is high, pick a winner, latch `id` and its `req_din`, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: assert `eng_start` and `ack[id]`, clear the timer, go to WAIT.
  - WAIT: the timer increments each cycle.
    - If `eng_done` is high: latch `eng_dout` into `rsp_data`, set `rsp_err`=0, go to RESP.
    - Else if timer == TIMEOUT-1: set `rsp_data`=0 and `rsp_err`=1, go to RESP.
  - RESP: assert `rsp_valid[id]`, set `ptr` = (id+1) mod N_REQ, go to IDLE.
- Arbitration:
  - Round-robin starting from `ptr`; the first set `req` bit at or after `ptr` (wrapping) wins.
  - `ptr` resets to 0 and updates only in RESP, including after a timeout.
- Requester rule:
  - Hold `req` high until `ack` is seen.
  - Drop `req` before `rsp_valid`.
  - Any `req` bit high while the scheduler is in IDLE is a new request.
  - `req` and `req_din` are ignored outside IDLE.
- Outputs:
  - All outputs are registered or decoded only from state, `id` and registered data.
  - There is no combinational path from inputs to outputs.
  - `rsp_data` and `rsp_err` hold their value until the next RESP.
- Data: operand and result are passed through unmodified. 16-bit overflow of large Fibonacci values is the engine's behaviour and is not checked here.
- Timer width: ceil(log2(TIMEOUT+1)) bits. The timer saturates and never wraps.
- Boundary conditions:
  - `eng_done` in IDLE, ISSUE or RESP: ignored.
  - `eng_done` in the same cycle the timer reaches TIMEOUT-1: done wins, `rsp_err`=0.
  - All `req` bits high continuously: grants rotate 0,1,2,3,0,…
  - Single requester: it is re-granted every job, and `ptr` still advances.
  - Reset asserted mid-job: the in-flight job is abandoned with no `rsp_valid`. The engine is expected to share `reset_n`.
- Reset values: state=IDLE, `ptr`=0, `id`=0, timer=0; `ack`, `rsp_valid`, `eng_start`, `busy`, `rsp_err` = 0; `rsp_data`, `eng_din` = 0.

## Timing
- Let cycle k be the IDLE cycle in which `req` is sampled high.
  - Cycle k+1: ISSUE, with `ack[id]`=1 and `eng_start`=1.
  - Cycle k+2 onward: WAIT.
- If `eng_done` is high in cycle m (a WAIT cycle):
  - Cycle m+1: RESP, with `rsp_valid[id]`=1 and valid data.
  - Cycle m+2: IDLE, and the next request can be sampled in this cycle.
- Overhead is 3 cycles per job plus engine latency; next ISSUE is at m+3 earliest.
- Timeout: RESP occurs exactly TIMEOUT+1 cycles after ISSUE when no `eng_done` arrives.
- `busy` rises in cycle k+1 and falls in the IDLE cycle after RESP.
- `eng_din` changes only on the edge entering ISSUE.

## Test plan
- Reset with `req`=0: all outputs 0, state IDLE. Then deassert `reset_n`, keep `req`=0 for 10 cycles: no `ack`, `busy`=0.
- Single job: `req[2]`=1, operand 10, engine model done after 12 cycles with value 55.
  - Expect `ack[2]` one cycle after `req`.
  - Expect `eng_din`=10 and one `eng_start` pulse.
  - Expect `rsp_valid[2]` one cycle after `eng_done`, with `rsp_data`=55, `rsp_err`=0.
- Fairness: all four `req` held high, operands 1..4, re-raised after each `ack`. Expect grant order 0,1,2,3,0,1 and results 1,1,2,3.
- Timeout: TIMEOUT=20, engine model never asserts done, `req[1]`=1, operand 5.
  - Expect `rsp_valid[1]` 21 cycles after ISSUE, with `rsp_err`=1 and `rsp_data`=0.
  - Expect `ptr`=2 afterwards.
- Done/timeout collision and stray done:
  - `eng_done` in the same cycle as timer = TIMEOUT-1, value 8: expect `rsp_err`=0, `rsp_data`=8.
  - `eng_done` pulsed while in IDLE: no `rsp_valid`.
- Reset mid-WAIT: assert `reset_n`=0 during WAIT, release, then issue `req[3]` with operand 7 (result 13). Expect no response for the abandoned job, `ptr`=0, and a correct response of 13 to requester 3.
